// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared FIFO sizing: default address width and the rule for deriving
// the pointer/occupancy width from it.
package fifo_ptr_ctrl_pkg;

    localparam int FIFO_ADDR_W = 3;

    // One extra bit over the address gives the wrap bit and lets count reach depth.
    function automatic int fifo_cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_ptr.sv
// Single FIFO pointer: address in the low bits, wrap bit in the MSB,
// natural binary rollover toggles the wrap bit.
module fifo_ptr
    import fifo_ptr_ctrl_pkg::*;
#(
    parameter int CNT_W = fifo_cnt_w(FIFO_ADDR_W)
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             inc,
    output logic [CNT_W-1:0] ptr
);

    localparam logic [CNT_W-1:0] PTR_ONE = CNT_W'(1);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer controller: accept/reject push and pop, drive storage
// strobes and addresses, and report occupancy, status and sticky errors.
module fifo_ptr_ctrl
    import fifo_ptr_ctrl_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int CNT_W  = fifo_cnt_w(ADDR_W)
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic              pop,
    input  logic [CNT_W-1:0]  thr_af,
    input  logic [CNT_W-1:0]  thr_ae,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic             addr_eq;
    logic             wrap_eq;

    fifo_ptr #(.CNT_W(CNT_W)) u_wr_ptr (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (wr_en),
        .ptr     (wr_ptr)
    );

    fifo_ptr #(.CNT_W(CNT_W)) u_rd_ptr (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (rd_en),
        .ptr     (rd_ptr)
    );

    assign addr_eq = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign wrap_eq = (wr_ptr[CNT_W-1] == rd_ptr[CNT_W-1]);

    assign empty   = addr_eq &  wrap_eq;
    assign full    = addr_eq & ~wrap_eq;
    assign count   = wr_ptr - rd_ptr;
    assign wr_addr = wr_ptr[ADDR_W-1:0];
    assign rd_addr = rd_ptr[ADDR_W-1:0];

    // Strobes are gated by reset so storage sees no writes while held in reset.
    assign rd_en = reset_L & pop & ~empty;
    assign wr_en = reset_L & push & (~full | rd_en);

    assign almost_full  = (count >= thr_af);
    assign almost_empty = (count <= thr_ae);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push & ~wr_en) overflow  <= 1'b1;
            if (pop  & ~rd_en) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl: a driver queues expected outputs from an
// occupancy-level model, a negedge monitor pops and compares them.
module tb_fifo_ptr_ctrl;

    localparam int ADDR_W = 3;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 8;

    logic             clk = 1'b0;
    logic             reset_L = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [CNT_W-1:0] thr_af = '0;
    logic [CNT_W-1:0] thr_ae = '0;
    logic             wr_en, rd_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [CNT_W-1:0] count;
    logic             full, empty, almost_full, almost_empty, overflow, underflow;

    fifo_ptr_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .pop          (pop),
        .thr_af       (thr_af),
        .thr_ae       (thr_ae),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wr_en, rd_en, wr_addr, rd_addr, count;
        int full, empty, af, ae, ovf, unf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: occupancy and total transfers as plain integers.
    int occ = 0;
    int wr_total = 0;
    int rd_total = 0;
    int m_ovf = 0;
    int m_unf = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(input exp_t e, input string tag);
        chk({tag, ".wr_en"},   int'(wr_en),        e.wr_en);
        chk({tag, ".rd_en"},   int'(rd_en),        e.rd_en);
        chk({tag, ".wr_addr"}, int'(wr_addr),      e.wr_addr);
        chk({tag, ".rd_addr"}, int'(rd_addr),      e.rd_addr);
        chk({tag, ".count"},   int'(count),        e.count);
        chk({tag, ".full"},    int'(full),         e.full);
        chk({tag, ".empty"},   int'(empty),        e.empty);
        chk({tag, ".af"},      int'(almost_full),  e.af);
        chk({tag, ".ae"},      int'(almost_empty), e.ae);
        chk({tag, ".ovf"},     int'(overflow),     e.ovf);
        chk({tag, ".unf"},     int'(underflow),    e.unf);
    endtask

    function automatic exp_t model_out(input int p, input int q, input int af,
                                       input int ae, input int in_reset);
        exp_t e;
        int rd;
        if (in_reset != 0) begin
            e.wr_en = 0; e.rd_en = 0; e.wr_addr = 0; e.rd_addr = 0; e.count = 0;
            e.full = 0; e.empty = 1; e.ae = 1; e.af = (af == 0) ? 1 : 0;
            e.ovf = 0; e.unf = 0;
        end else begin
            rd        = (q != 0 && occ > 0) ? 1 : 0;
            e.rd_en   = rd;
            e.wr_en   = (p != 0 && (occ < DEPTH || rd != 0)) ? 1 : 0;
            e.wr_addr = wr_total % DEPTH;
            e.rd_addr = rd_total % DEPTH;
            e.count   = occ;
            e.full    = (occ == DEPTH) ? 1 : 0;
            e.empty   = (occ == 0) ? 1 : 0;
            e.af      = (occ >= af) ? 1 : 0;
            e.ae      = (occ <= ae) ? 1 : 0;
            e.ovf     = m_ovf;
            e.unf     = m_unf;
        end
        return e;
    endfunction

    task automatic model_step(input exp_t e, input int p, input int q);
        if (p != 0 && e.wr_en == 0) m_ovf = 1;
        if (q != 0 && e.rd_en == 0) m_unf = 1;
        occ      = occ + e.wr_en - e.rd_en;
        wr_total = wr_total + e.wr_en;
        rd_total = rd_total + e.rd_en;
    endtask

    task automatic cycle(input int p, input int q, input int af, input int ae);
        exp_t e;
        @(posedge clk);
        #1;
        push = (p != 0); pop = (q != 0);
        thr_af = CNT_W'(af); thr_ae = CNT_W'(ae);
        reset_L = 1'b1;
        e = model_out(p, q, af, ae, 0);
        sb.push_back(e);
        model_step(e, p, q);
    endtask

    // Reset asserted between edges; outputs are also checked right away.
    task automatic reset_cycle(input int p, input int q, input int af, input int ae);
        exp_t e;
        @(posedge clk);
        #1;
        push = (p != 0); pop = (q != 0);
        thr_af = CNT_W'(af); thr_ae = CNT_W'(ae);
        reset_L = 1'b0;
        occ = 0; wr_total = 0; rd_total = 0; m_ovf = 0; m_unf = 0;
        e = model_out(p, q, af, ae, 1);
        sb.push_back(e);
        #1;
        compare(e, "rst_now");
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            compare(e, "mon");
        end
    end

    initial begin
        int bias;
        int p, q;
        reset_cycle(0, 0, 6, 2);
        repeat (8) cycle(1, 0, 6, 2);
        cycle(1, 0, 6, 2);
        repeat (3) cycle(1, 1, 6, 2);
        repeat (8) cycle(0, 1, 6, 2);
        cycle(1, 1, 6, 2);
        cycle(0, 0, 6, 2);
        reset_cycle(0, 0, 0, 2);
        repeat (5) cycle(1, 0, 6, 2);
        reset_cycle(1, 1, 6, 2);
        cycle(0, 0, 6, 2);

        for (int i = 0; i < 800; i++) begin
            bias = (i / 40) % 3;
            p = ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 2 : 5))) ? 1 : 0;
            q = ($urandom_range(0, 9) < (bias == 0 ? 2 : (bias == 1 ? 8 : 5))) ? 1 : 0;
            if ($urandom_range(0, 79) == 0)
                reset_cycle(p, q, $urandom_range(0, 15), $urandom_range(0, 15));
            else
                cycle(p, q, $urandom_range(0, 10), $urandom_range(0, 10));
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
